// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects, samples each channel after DWELL cycles
// and hands the 4-bit snapshot downstream over valid/ready. Optional frame parity via SCAN_PARITY_EN.
module mux4_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mux_o,
    output logic       s1,
    output logic       s2,
    output logic [3:0] frame,
    output logic       frame_valid,
`ifdef SCAN_PARITY_EN
    output logic       frame_parity,
`endif
    input  logic       frame_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     r_state;
    logic [1:0] r_ch;
    logic [7:0] r_cnt;
    // Channel 3 goes straight into the frame, so only a..c need shadowing.
    logic [2:0] r_shadow;
    logic [3:0] r_frame;
    logic       r_valid;
    logic       w_dwell_done;
`ifdef SCAN_PARITY_EN
    logic       r_parity;
`endif

    assign w_dwell_done = (r_cnt == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_frame  <= '0;
            r_valid  <= 1'b0;
`ifdef SCAN_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ch    <= '0;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                    if (en) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!en) begin
                        r_state  <= IDLE;
                        r_ch     <= '0;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end else if (w_dwell_done) begin
                        r_cnt <= '0;
                        if (r_ch == 2'd3) begin
                            r_frame <= {mux_o, r_shadow};
`ifdef SCAN_PARITY_EN
                            r_parity <= ^{mux_o, r_shadow};
`endif
                            r_valid <= 1'b1;
                            r_ch    <= '0;
                            r_state <= HOLD;
                        end else begin
                            case (r_ch)
                                2'd0:    r_shadow[0] <= mux_o;
                                2'd1:    r_shadow[1] <= mux_o;
                                default: r_shadow[2] <= mux_o;
                            endcase
                            r_ch <= r_ch + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // Frame stays offered regardless of en until the consumer takes it.
                    if (frame_ready) begin
                        r_valid <= 1'b0;
                        r_ch    <= '0;
                        r_cnt   <= '0;
                        r_state <= en ? SCAN : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s1          = r_ch[1];
    assign s2          = r_ch[0];
    assign frame       = r_frame;
    assign frame_valid = r_valid;
`ifdef SCAN_PARITY_EN
    assign frame_parity = r_parity;
`endif

endmodule
